// File: rtl/mskaes_round_ctrl.sv
// Round sequencer for a masked AES-128 datapath with a pipelined S-box.
// Each round feeds the four state columns, then the rotated last key word,
// then drains the S-box pipeline before the next round starts. Ten rounds
// per block; the ciphertext is held in DONE until the consumer takes it.
// Outputs other than in_ready are registered from next-state values, so each
// output lines up with the state it describes.

module mskaes_round_ctrl #(
    parameter int unsigned SBOX_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       feed_sbox,
    output logic [1:0] col_idx,
    output logic       key_sbox,
    output logic [3:0] round_idx,
    output logic       last_round,
    output logic       rcon_rst,
    output logic       rcon_update,
    output logic       mask_rcon
);

    localparam logic [3:0] WaitInit  = 4'(SBOX_LAT - 1);
    localparam logic [3:0] LastRound = 4'd9;
    localparam logic [1:0] LastCol   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StFeed,
        StKey,
        StWait,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [1:0] col_q, col_d;
    logic [3:0] cnt_q, cnt_d;

    logic out_valid_q, out_valid_d;
    logic busy_q, busy_d;
    logic feed_q, feed_d;
    logic key_q, key_d;
    logic last_q, last_d;
    logic rcon_rst_q, rcon_rst_d;
    logic rcon_upd_q, rcon_upd_d;
    logic mask_q, mask_d;

    logic accept;

    // Only IDLE accepts, and never while reset is asserted.
    assign in_ready = (state_q == StIdle) && !rst;
    assign accept   = in_valid && in_ready;

    // Next-state logic: column feed, key feed, pipeline drain, round advance.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        col_d   = col_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StFeed;
                    round_d = 4'd0;
                    col_d   = 2'd0;
                end
            end
            StFeed: begin
                if (col_q == LastCol) begin
                    state_d = StKey;
                    col_d   = 2'd0;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            StKey: begin
                state_d = StWait;
                cnt_d   = WaitInit;
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    if (round_q == LastRound) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFeed;
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                // Return round_idx to 0 so IDLE looks the same after every block.
                if (out_ready) begin
                    state_d = StIdle;
                    round_d = 4'd0;
                end
            end
            default: begin
                state_d = StIdle;
                round_d = 4'd0;
                col_d   = 2'd0;
                cnt_d   = 4'd0;
            end
        endcase

        // Synchronous reset aborts any block in flight.
        if (rst) begin
            state_d = StIdle;
            round_d = 4'd0;
            col_d   = 2'd0;
            cnt_d   = 4'd0;
        end
    end

    // Output decode from the next state, registered alongside it.
    always_comb begin
        busy_d      = (state_d != StIdle);
        feed_d      = (state_d == StFeed);
        key_d       = (state_d == StKey);
        mask_d      = (state_d == StKey);
        out_valid_d = (state_d == StDone);
        rcon_rst_d  = (state_d == StIdle);
        last_d      = (round_d == LastRound);
        // Advance the round constant in the final drain cycle of rounds 0..8.
        rcon_upd_d  = (state_d == StWait) && (cnt_d == 4'd0) && (round_d != LastRound);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        round_q     <= round_d;
        col_q       <= col_d;
        cnt_q       <= cnt_d;
        out_valid_q <= out_valid_d;
        busy_q      <= busy_d;
        feed_q      <= feed_d;
        key_q       <= key_d;
        last_q      <= last_d;
        rcon_rst_q  <= rcon_rst_d;
        rcon_upd_q  <= rcon_upd_d;
        mask_q      <= mask_d;
    end

    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign feed_sbox   = feed_q;
    assign col_idx     = col_q;
    assign key_sbox    = key_q;
    assign round_idx   = round_q;
    assign last_round  = last_q;
    assign rcon_rst    = rcon_rst_q;
    assign rcon_update = rcon_upd_q;
    assign mask_rcon   = mask_q;

endmodule

// File: tb/tb_mskaes_round_ctrl.sv
// Bench for mskaes_round_ctrl: two instances (SBOX_LAT 4 and 1), a per-cycle
// reference model based on cycle position within a block, a round-constant
// generator driven by the DUT, a directed vector table and random traffic.

module tb_mskaes_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv      [2];
    logic       ordy    [2];
    logic       in_rdy  [2];
    logic       out_vld [2];
    logic       bsy     [2];
    logic       feed    [2];
    logic [1:0] col     [2];
    logic       key     [2];
    logic [3:0] rnd     [2];
    logic       lastr   [2];
    logic       rrst    [2];
    logic       rupd    [2];
    logic       mrc     [2];

    mskaes_round_ctrl #(.SBOX_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(in_rdy[0]),
        .out_valid(out_vld[0]), .out_ready(ordy[0]), .busy(bsy[0]),
        .feed_sbox(feed[0]), .col_idx(col[0]), .key_sbox(key[0]),
        .round_idx(rnd[0]), .last_round(lastr[0]), .rcon_rst(rrst[0]),
        .rcon_update(rupd[0]), .mask_rcon(mrc[0])
    );

    mskaes_round_ctrl #(.SBOX_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(in_rdy[1]),
        .out_valid(out_vld[1]), .out_ready(ordy[1]), .busy(bsy[1]),
        .feed_sbox(feed[1]), .col_idx(col[1]), .key_sbox(key[1]),
        .round_idx(rnd[1]), .last_round(lastr[1]), .rcon_rst(rrst[1]),
        .rcon_update(rupd[1]), .mask_rcon(mrc[1])
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input int i, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, i, $time, got, want);
    endtask

    // {in_ready, out_valid, busy, feed, col[1:0], key, round[3:0], last, rcon_rst, rcon_update, mask}
    function automatic logic [14:0] pk(input bit ir, input bit ov, input bit bs, input bit fd,
                                       input int c, input bit ky, input int r, input bit lr,
                                       input bit rr, input bit ru, input bit mk);
        return {ir, ov, bs, fd, 2'(c), ky, 4'(r), lr, rr, ru, mk};
    endfunction

    function automatic logic [14:0] obs(input int i);
        return {in_rdy[i], out_vld[i], bsy[i], feed[i], col[i], key[i], rnd[i], lastr[i],
                rrst[i], rupd[i], mrc[i]};
    endfunction

    // Reference model: mode 0 idle, 1 in block at cycle t (1-based), 2 done.
    int m_mode [2] = '{0, 0};
    int m_t    [2] = '{0, 0};
    int lat    [2] = '{4, 1};

    function automatic logic [14:0] model_out(input int i);
        int len, r, p;
        len = 5 + lat[i];
        if (m_mode[i] == 0) return pk(!rst, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        if (m_mode[i] == 2) return pk(0, 1, 1, 0, 0, 0, 9, 1, 0, 0, 0);
        r = (m_t[i] - 1) / len;
        p = (m_t[i] - 1) % len;
        return pk(0, 0, 1, p < 4, (p < 4) ? p : 0, p == 4, r, r == 9, 0,
                  (p == len - 1) && (r < 9), p == 4);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) m_mode[i] = 0;
            else if (m_mode[i] == 0) begin
                if (iv[i]) begin m_mode[i] = 1; m_t[i] = 1; end
            end else if (m_mode[i] == 1) begin
                m_t[i]++;
                if (m_t[i] > 10 * (5 + lat[i])) m_mode[i] = 2;
            end else if (ordy[i]) m_mode[i] = 0;
        end
    end

    // Round-constant generator fed by the DUT controls.
    logic [7:0] rc [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rrst[i]) rc[i] <= 8'h01;
            else if (rupd[i]) rc[i] <= {rc[i][6:0], 1'b0} ^ (rc[i][7] ? 8'h1b : 8'h00);
        end
    end

    logic [7:0] rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    int upd_cnt [2] = '{0, 0};
    bit done_seen [2] = '{0, 0};

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("outputs", i, 32'(obs(i)), 32'(model_out(i)));
                if (m_mode[i] == 1 && ((m_t[i] - 1) % (5 + lat[i])) == 4)
                    chk("rcon", i, 32'(rc[i]), 32'(rcon_t[(m_t[i] - 1) / (5 + lat[i])]));
                if (m_mode[i] == 0) upd_cnt[i] = 0;
                else if (rupd[i] === 1'b1) upd_cnt[i]++;
                if (m_mode[i] == 2 && !done_seen[i]) begin
                    chk("rcon_update_count", i, 32'(upd_cnt[i]), 32'd9);
                    done_seen[i] = 1'b1;
                end
                if (m_mode[i] != 2) done_seen[i] = 1'b0;
            end
        end
    end

    // Advance n clock edges, then settle just past the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ov(input int i, output int n);
        n = 0;
        while (out_vld[i] !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
    endtask

    typedef struct {
        bit          rst;
        bit          iv;
        bit          ordy;
        int          cyc;
        logic [14:0] exp;
    } vec_t;

    vec_t vt [14];
    int   n;

    initial begin
        rst = 1'b1;
        iv = '{0, 0};
        ordy = '{0, 0};
        @(posedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b1;

        vt[0]  = '{1, 0, 0, 2,  pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[1]  = '{0, 0, 0, 1,  pk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[2]  = '{0, 1, 0, 1,  pk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
        vt[3]  = '{0, 0, 0, 3,  pk(0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0)};
        vt[4]  = '{0, 0, 0, 1,  pk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1)};
        vt[5]  = '{0, 0, 0, 4,  pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)};
        vt[6]  = '{0, 0, 0, 1,  pk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0)};
        vt[7]  = '{0, 0, 1, 80, pk(0, 0, 1, 0, 0, 0, 9, 1, 0, 0, 0)};
        vt[8]  = '{0, 0, 0, 1,  pk(0, 1, 1, 0, 0, 0, 9, 1, 0, 0, 0)};
        vt[9]  = '{0, 1, 0, 20, pk(0, 1, 1, 0, 0, 0, 9, 1, 0, 0, 0)};
        vt[10] = '{0, 0, 1, 1,  pk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[11] = '{0, 1, 0, 1,  pk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
        vt[12] = '{1, 0, 0, 1,  pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        vt[13] = '{0, 0, 0, 1,  pk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};

        for (int k = 0; k < 14; k++) begin
            rst = vt[k].rst;
            iv[0] = vt[k].iv;
            ordy[0] = vt[k].ordy;
            tick(vt[k].cyc);
            chk($sformatf("table%0d", k), 0, 32'(obs(0)), 32'(vt[k].exp));
        end

        // Single-block latency for both pipeline depths.
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b1;
            tick(1);
            iv[i] = 1'b0;
            wait_ov(i, n);
            chk("out_valid_cycle", i, 32'(1 + n), (i == 0) ? 32'd91 : 32'd61);
            ordy[i] = 1'b1;
            tick(1);
            ordy[i] = 1'b0;
            chk("idle_after_done", i, 32'(in_rdy[i]), 32'd1);
        end

        // Back-to-back: accept one cycle after the handshake, rcon restarts.
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        tick(1);
        wait_ov(0, n);
        chk("b2b_first_done", 0, 32'(n), 32'd90);
        tick(1);
        chk("b2b_idle", 0, 32'(obs(0)), 32'(pk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
        tick(1);
        chk("b2b_second_feed", 0, 32'(obs(0)), 32'(pk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0)));
        iv[0] = 1'b0;
        tick(4);
        chk("b2b_rcon_restart", 0, 32'(rc[0]), 32'h01);
        wait_ov(0, n);
        tick(1);
        ordy[0] = 1'b0;

        // Reset during round 5 WAIT.
        iv[0] = 1'b1;
        tick(1);
        iv[0] = 1'b0;
        tick(51);
        chk("r5_wait", 0, 32'(obs(0)), 32'(pk(0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0)));
        rst = 1'b1;
        tick(1);
        chk("abort_idle", 0, 32'(bsy[0]), 32'd0);
        rst = 1'b0;
        tick(1);
        chk("ready_after_rst", 0, 32'(in_rdy[0]), 32'd1);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (out_vld[0] !== 1'b0) n++;
            tick(1);
        end
        chk("no_out_valid_after_abort", 0, 32'(n), 32'd0);

        // Random traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                iv[i] = 1'($urandom_range(0, 1));
                ordy[i] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mskaes_round_ctrl.md
MSKAES_ROUND_CTRL -- requirements
Module: mskaes_round_ctrl

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 4: masked S-box pipeline latency in cycles, legal range 1..15.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  new block/key sharing available.
REQ-005 SHALL have port in_ready  output  1  controller accepts a new block.
REQ-006 SHALL have port out_valid  output  1  ciphertext sharing is valid.
REQ-007 SHALL have port out_ready  input  1  consumer takes the ciphertext.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port feed_sbox  output  1  the datapath presents a state column to the S-box this cycle.
REQ-010 SHALL have port col_idx  output  2  index of the column being fed, 0..3.
REQ-011 SHALL have port key_sbox  output  1  the datapath presents the rotated last key word to the S-box this cycle.
REQ-012 SHALL have port round_idx  output  4  current round, 0..9.
REQ-013 SHALL have port last_round  output  1  round_idx==9; the datapath bypasses MixColumns.
REQ-014 SHALL have port rcon_rst  output  1  drives the round-constant generator reset, loading 0x01.
REQ-015 SHALL have port rcon_update  output  1  advances the round-constant generator.
REQ-016 SHALL have port mask_rcon  output  1  ungates the round constant into the key word.

Function
REQ-017 SHALL implement states IDLE, FEED, KEY, WAIT, DONE.
REQ-018 in_ready SHALL equal (state==IDLE && !rst); a transfer occurs on in_valid && in_ready.
REQ-019 IDLE: rcon_rst=1; on transfer -> FEED with round_idx=0 and col_idx=0.
REQ-020 FEED: feed_sbox=1, one cycle per column, col_idx 0,1,2,3; after col_idx==3 -> KEY, and col_idx wraps to 0.
REQ-021 KEY: exactly one cycle with key_sbox=1 and mask_rcon=1; then -> WAIT with wait counter = SBOX_LAT-1.
REQ-022 WAIT: lasts exactly SBOX_LAT cycles, counting the counter down to 0.
REQ-023 In the last WAIT cycle: if round_idx<9, then rcon_update=1, round_idx increments, and the next state is FEED; if round_idx==9, the next state is DONE and rcon_update=0.
REQ-024 rcon_update SHALL be asserted exactly 9 times per block; rcon_rst and rcon_update SHALL never be high together.
REQ-025 mask_rcon SHALL be 0 in every state except KEY.
REQ-026 feed_sbox and key_sbox SHALL be mutually exclusive and both 0 in IDLE, WAIT and DONE.
REQ-027 Each round SHALL last 5+SBOX_LAT cycles; the first FEED cycle SHALL directly follow the accept edge.
REQ-028 DONE: out_valid=1, held stable until out_ready; on out_valid && out_ready -> IDLE; out_ready SHALL be ignored in all other states.
REQ-029 No new block SHALL be accepted before the DONE handshake completes; in_valid outside IDLE SHALL have no effect.
REQ-030 last_round SHALL equal (round_idx==9) in every state.

Reset
REQ-031 While rst is high: state=IDLE, round_idx=0, col_idx=0, wait counter=0, and every output 0 except rcon_rst=1.
REQ-032 rst asserted mid-block SHALL abort the block: IDLE in the following cycle, no out_valid, and the next accepted block starts at round 0 with rcon 0x01.

Verification
REQ-033 Single block, SBOX_LAT=4: accept at edge 0 -> FEED col0 at cycle 1, round 9 ends at cycle 90, out_valid=1 from cycle 91.
REQ-034 Rcon trace: a generator fed by rcon_rst/rcon_update SHALL show 01,02,04,08,10,20,40,80,1b,36 in the 10 KEY cycles in order.
REQ-035 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid held, in_ready=0 and outputs unchanged; single-cycle out_ready -> IDLE next cycle.
REQ-036 Back-to-back: in_valid held high and out_ready=1 -> second accept exactly one cycle after the DONE handshake; the second block's rcon restarts at 0x01.
REQ-037 Reset at round 5 WAIT -> IDLE next cycle, in_ready=1 the cycle after rst falls, out_valid never asserted.
REQ-038 SBOX_LAT=1 -> round length 6 cycles, out_valid at cycle 61, same rcon trace as REQ-034.
